// File: rtl/vram_wr_buf.sv
// CPU-to-VRAM write buffer: queues CPU writes and slips each one into the free slots 1-3 of the 8-pixel fetch cycle.
// Optional build macro VRAM_WR_BUF_COALESCE_EN merges a write into the newest queued entry at the same address.
module vram_wr_buf #(
    parameter int DEPTH = 4
) (
    input  logic                     pixClock,
    input  logic                     reset,
    input  logic                     cpuWrStb,
    input  logic [12:0]              cpuWrAddr,
    input  logic [7:0]               cpuWrData,
    input  logic [9:0]               hCount,
    input  logic [12:0]              vidAddr,
    output logic [12:0]              vramAddr,
    output logic [7:0]               vramDataOut,
    output logic                     vramDataOE,
    output logic                     nvramWE,
    output logic                     bufEmpty,
    output logic [$clog2(DEPTH):0]   bufCount,
    output logic                     overflow,
    output logic [1:0]               dbgState
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 21;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   w_last_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            r_empty;
    logic            r_overflow;
    logic [12:0]     r_wr_addr;
    logic [7:0]      r_wr_data;
    logic            w_slot_ok;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_coal;
    logic            w_drop;
    logic            w_unused_hcount;

    // Only the low three bits pick the slot inside the 8-pixel fetch cycle.
    assign w_unused_hcount = ^hCount[9:3];
    assign w_slot_ok  = (hCount[2:0] == 3'd1) || (hCount[2:0] == 3'd2) || (hCount[2:0] == 3'd3);
    assign w_pop      = (r_state == IDLE) && (r_count != '0) && w_slot_ok;
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_last_ptr = r_wr_ptr - AW'(1);

`ifdef VRAM_WR_BUF_COALESCE_EN
    // With one entry that is leaving this edge there is nothing left to merge into.
    assign w_coal = cpuWrStb && (r_count != '0) && (r_mem[w_last_ptr][20:8] == cpuWrAddr)
                    && !(w_pop && (r_count == CW'(1)));
`else
    assign w_coal = 1'b0;
`endif

    assign w_push = cpuWrStb && !w_coal && (!w_full || w_pop);
    assign w_drop = cpuWrStb && !w_coal && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        nvramWE     = 1'b1;
        vramDataOE  = 1'b1;
        vramAddr    = r_wr_addr;
        case (r_state)
            IDLE: begin
                vramDataOE = 1'b0;
                vramAddr   = vidAddr;
                if (w_pop) w_next = SETUP;
            end
            SETUP:   w_next = STROBE;
            STROBE: begin
                nvramWE = 1'b0;
                w_next  = HOLD;
            end
            HOLD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pixClock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_wr_addr <= r_mem[r_rd_ptr][20:8];
                r_wr_data <= r_mem[r_rd_ptr][7:0];
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge pixClock) begin
        if (!reset) begin
            if (w_push)      r_mem[r_wr_ptr]       <= {cpuWrAddr, cpuWrData};
            else if (w_coal) r_mem[w_last_ptr][7:0] <= cpuWrData;
        end
    end

    assign vramDataOut = r_wr_data;
    assign bufEmpty    = r_empty;
    assign bufCount    = r_count;
    assign overflow    = r_overflow;
    assign dbgState    = r_state;

endmodule

// File: tb/tb_vram_wr_buf.sv
// Directed bench for vram_wr_buf: a queue-based reference model is stepped each clock and every output is compared.
module tb_vram_wr_buf;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          pixClock;
    logic          reset;
    logic          cpuWrStb;
    logic [12:0]   cpuWrAddr;
    logic [7:0]    cpuWrData;
    logic [9:0]    hCount;
    logic [12:0]   vidAddr;
    logic [12:0]   vramAddr;
    logic [7:0]    vramDataOut;
    logic          vramDataOE;
    logic          nvramWE;
    logic          bufEmpty;
    logic [CW-1:0] bufCount;
    logic          overflow;
    logic [1:0]    dbgState;

    int          total = 0;
    int          bad   = 0;
    int          n_wr  = 0;
    int          n0;
    int          m_phase = 0;
    logic        m_ovf   = 1'b0;
    logic [20:0] m_cur   = '0;
    logic [20:0] exp_q[$];
    bit          h_run   = 1'b1;
    bit          found;

    vram_wr_buf #(.DEPTH(DEPTH)) dut (
        .pixClock    (pixClock),
        .reset       (reset),
        .cpuWrStb    (cpuWrStb),
        .cpuWrAddr   (cpuWrAddr),
        .cpuWrData   (cpuWrData),
        .hCount      (hCount),
        .vidAddr     (vidAddr),
        .vramAddr    (vramAddr),
        .vramDataOut (vramDataOut),
        .vramDataOE  (vramDataOE),
        .nvramWE     (nvramWE),
        .bufEmpty    (bufEmpty),
        .bufCount    (bufCount),
        .overflow    (overflow),
        .dbgState    (dbgState)
    );

    initial begin
        pixClock = 1'b0;
        forever #5 pixClock = ~pixClock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict the edge, advance the model, compare every output, then move hCount on.
    task automatic tick();
        bit       pop_pred;
        bit       coal;
        logic [2:0] slot;
        slot     = hCount[2:0];
        pop_pred = (m_phase == 0) && (exp_q.size() != 0) && (slot inside {3'd1, 3'd2, 3'd3});
        @(posedge pixClock);
        #1;
        if (reset) begin
            exp_q.delete();
            m_cur   = '0;
            m_phase = 0;
            m_ovf   = 1'b0;
        end else begin
            if (pop_pred) begin
                m_cur   = exp_q.pop_front();
                m_phase = 1;
            end else if (m_phase != 0) begin
                m_phase = (m_phase + 1) % 4;
            end
            if (cpuWrStb) begin
                coal = 1'b0;
`ifdef VRAM_WR_BUF_COALESCE_EN
                if (exp_q.size() > 0 && exp_q[exp_q.size()-1][20:8] == cpuWrAddr) begin
                    exp_q[exp_q.size()-1][7:0] = cpuWrData;
                    coal = 1'b1;
                end
`endif
                if (!coal) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back({cpuWrAddr, cpuWrData});
                    else m_ovf = 1'b1;
                end
            end
        end
        chk("state",       32'(dbgState),    32'(m_phase));
        chk("nvramWE",     32'(nvramWE),     32'(m_phase != 2));
        chk("vramDataOE",  32'(vramDataOE),  32'(m_phase != 0));
        chk("vramAddr",    32'(vramAddr),    32'((m_phase == 0) ? vidAddr : m_cur[20:8]));
        chk("vramDataOut", 32'(vramDataOut), 32'(m_cur[7:0]));
        chk("bufCount",    32'(bufCount),    32'(exp_q.size()));
        chk("bufEmpty",    32'(bufEmpty),    32'(exp_q.size() == 0));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        if (nvramWE === 1'b0) begin
            n_wr++;
            chk("we_slot", 32'(slot inside {3'd2, 3'd3, 3'd4}), 32'd1);
        end
        if (h_run) hCount = hCount + 10'd1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [12:0] a, input logic [7:0] d);
        cpuWrStb  = 1'b1;
        cpuWrAddr = a;
        cpuWrData = d;
        tick();
        cpuWrStb  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cpuWrStb  = 1'b0;
        cpuWrAddr = '0;
        cpuWrData = '0;
        hCount    = 10'd0;
        vidAddr   = 13'h0777;
        ticks(2);
        reset = 1'b0;

        // Single write arriving at slot 0.
        hCount = 10'd0;
        n0 = n_wr;
        strobe(13'h0155, 8'hA5);
        ticks(6);
        chk("req036_writes", 32'(n_wr - n0), 32'd1);
        chk("req036_empty",  32'(bufEmpty),  32'd1);

        // Write arriving at slot 4 must wait for the next slot 1.
        hCount  = 10'd4;
        vidAddr = 13'h1ABC;
        n0 = n_wr;
        strobe(13'h00AA, 8'h3C);
        ticks(10);
        chk("req037_writes", 32'(n_wr - n0), 32'd1);

        // Fill while parked at slot 6, one strobe too many.
        h_run  = 1'b0;
        hCount = 10'd6;
        for (int i = 0; i < 5; i++) strobe(13'h0100 + 13'(i), 8'($urandom_range(0, 255)));
        chk("req038_count", 32'(bufCount), 32'd4);
        chk("req038_ovf",   32'(overflow), 32'd1);
        h_run = 1'b1;
        n0 = n_wr;
        ticks(40);
        chk("req038_writes", 32'(n_wr - n0), 32'd4);

        // Two writes to the same address while queued.
        h_run  = 1'b0;
        hCount = 10'd6;
        strobe(13'h0010, 8'h11);
        strobe(13'h0010, 8'h22);
`ifdef VRAM_WR_BUF_COALESCE_EN
        chk("req039_count", 32'(bufCount), 32'd1);
`else
        chk("req039_count", 32'(bufCount), 32'd2);
`endif
        h_run = 1'b1;
        n0 = n_wr;
        ticks(24);
`ifdef VRAM_WR_BUF_COALESCE_EN
        chk("req039_writes", 32'(n_wr - n0), 32'd1);
`else
        chk("req039_writes", 32'(n_wr - n0), 32'd2);
`endif

        // Random traffic over a small address set, then drain.
        for (int i = 0; i < 200; i++) begin
            cpuWrStb  = ($urandom_range(0, 2) == 0);
            cpuWrAddr = 13'h0040 + 13'($urandom_range(0, 3));
            cpuWrData = 8'($urandom_range(0, 255));
            vidAddr   = 13'($urandom_range(0, 8191));
            tick();
        end
        cpuWrStb = 1'b0;
        ticks(48);
        chk("drain_empty", 32'(bufEmpty), 32'd1);

        // Reset while a write is in its strobe cycle with entries still queued.
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        h_run  = 1'b0;
        hCount = 10'd6;
        for (int i = 0; i < 4; i++) strobe(13'h0200 + 13'(i), 8'h50 + 8'(i));
        h_run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (m_phase == 2) found = 1'b1;
        end
        chk("req040_reach_strobe", 32'(found),    32'd1);
        chk("req040_queued",       32'(bufCount), 32'd3);
        reset     = 1'b1;
        cpuWrStb  = 1'b1;
        cpuWrAddr = 13'h1FFF;
        cpuWrData = 8'hEE;
        tick();
        reset    = 1'b0;
        cpuWrStb = 1'b0;
        chk("req040_we",    32'(nvramWE),    32'd1);
        chk("req040_oe",    32'(vramDataOE), 32'd0);
        chk("req040_count", 32'(bufCount),   32'd0);
        n0 = n_wr;
        ticks(24);
        chk("req040_no_writes", 32'(n_wr - n0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vram_wr_buf.md
VRAM_WR_BUF -- requirements
Module: vram_wr_buf

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, 2..16.
REQ-002 pixClock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cpuWrStb  in  1  one-cycle write request, already synchronized to pixClock.
REQ-005 cpuWrAddr  in  13  VRAM byte address of the CPU write.
REQ-006 cpuWrData  in  8  CPU write data.
REQ-007 hCount  in  10  horizontal pixel counter from the timing stage.
REQ-008 vidAddr  in  13  video fetch address from the downstream video output stage.
REQ-009 vramAddr  out  13  muxed VRAM address.
REQ-010 vramDataOut  out  8  data driven onto the VRAM bus during writes.
REQ-011 vramDataOE  out  1  high = drive vramDataOut onto the VRAM bus.
REQ-012 nvramWE  out  1  active-low VRAM write strobe.
REQ-013 bufEmpty  out  1  FIFO holds zero entries.
REQ-014 bufCount  out  $clog2(DEPTH)+1  current entry count.
REQ-015 overflow  out  1  sticky flag: a write was dropped.

Function
REQ-016 The FIFO SHALL push {cpuWrAddr,cpuWrData} on cpuWrStb and pop in arrival order.
REQ-017 The FSM SHALL use four states: IDLE, SETUP, STROBE, HOLD; each lasts exactly one cycle except IDLE.
REQ-018 IDLE->SETUP SHALL occur only when the FIFO is non-empty and hCount[2:0] is 1, 2 or 3; the pop SHALL occur on that same edge, latching the entry into the write register.
REQ-019 The transitions SETUP->STROBE->HOLD->IDLE SHALL be unconditional, so a write never overlaps video read slots 6, 7 or 0.
REQ-020 In SETUP and HOLD: nvramWE=1, vramDataOE=1. In STROBE: nvramWE=0, vramDataOE=1. In IDLE: nvramWE=1, vramDataOE=0.
REQ-021 vramAddr SHALL equal the write-register address in SETUP/STROBE/HOLD, and vidAddr in IDLE (combinational mux).
REQ-022 vramDataOut SHALL equal the write-register data in every state.
REQ-023 A push when full SHALL be accepted only if a pop occurs on the same edge; otherwise it is dropped and overflow SHALL set.
REQ-024 A simultaneous push and pop SHALL leave bufCount unchanged.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 bufEmpty and bufCount SHALL be registered and reflect the post-edge FIFO state.
REQ-027 A new write SHALL NOT start until HOLD completes; the minimum spacing between strobes is 4 cycles.

Reset
REQ-028 While reset=1 at an edge, the block SHALL clear to: state IDLE, bufCount=0, bufEmpty=1, overflow=0, nvramWE=1, vramDataOE=0, pointers 0, write register 0.
REQ-029 A reset in STROBE SHALL raise nvramWE on that edge; the pending write and all queued entries SHALL be discarded.
REQ-030 A cpuWrStb coincident with reset SHALL be ignored.
REQ-031 overflow SHALL clear only on reset.

Configuration
REQ-032 Macro VRAM_WR_BUF_COALESCE_EN, when defined, enables write coalescing.
REQ-033 Coalescing rule: a push whose address equals the newest queued, not-being-popped entry SHALL overwrite that entry's data without incrementing bufCount.
REQ-034 Coalescing SHALL NOT apply when bufCount=1 and a pop occurs on the same edge; the write is pushed normally instead.
REQ-035 With the macro undefined, every accepted strobe SHALL push a new entry.

Verification
REQ-036 Reset, then one strobe with addr 0x0155, data 0xA5 at hCount[2:0]=0 -> SETUP at slot 1; nvramWE low only at slot 2; vramAddr=0x0155 and vramDataOut=0xA5 for slots 1-3; bufEmpty=1 afterward.
REQ-037 Strobe arriving at hCount[2:0]=4 -> FSM waits in IDLE through slots 4-7 and 0, then starts at slot 1; vramAddr=vidAddr during slot 7.
REQ-038 DEPTH=4, hold hCount[2:0]=6 and issue 5 strobes -> bufCount=4, overflow=1; after the hold is released, exactly 4 strobes occur in order.
REQ-039 Two strobes to 0x0010 (data 0x11, then 0x22) while queued -> with COALESCE_EN: bufCount=1 and one write of 0x22; without it: two writes.
REQ-040 Assert reset during STROBE with 3 entries queued -> next cycle nvramWE=1, vramDataOE=0, bufCount=0, no further strobes.
